// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Package     : parking_pkg
// Description : Shared types for the parking-lot barrier arbiter: gate FSM
//               states, lane identifiers and the round-robin lane picker.
// Revision    : 1.0  initial release
// ============================================================================
package parking_pkg;

    // Gate controller states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2,
        CLOSING    = 2'd3
    } gate_state_t;

    // Lane identifiers, also used to remember who was granted last
    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } lane_t;

    // When both lanes contend, the lane that was not served last wins
    function automatic lane_t rr_pick(input lane_t last_lane);
        return (last_lane == EXIT) ? ENTRY : EXIT;
    endfunction

endpackage : parking_pkg
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
// Module      : gate_timer
// Description : Up-counter with synchronous clear and enable. Stops at the
//               supplied limit and flags when the count equals that limit.
//               The owner swaps the limit depending on which phase it times.
// Revision    : 1.0  initial release
// ============================================================================
module gate_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_at_limit
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise advance until the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != i_limit)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_at_limit = (cnt_q == i_limit);

endmodule : gate_timer
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Shares one barrier gate between the entry and exit lanes.
//               Grants one lane at a time (round-robin under contention),
//               keeps the occupancy count, blocks entry when full and exit
//               when empty, and times out a grant that never completes.
// Revision    : 1.0  initial release
// ============================================================================
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY      = 9,
    parameter int CNT_W         = 4,
    parameter int TIMEOUT_TICKS = 400,
    parameter int CLOSE_TICKS   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             entry_done,
    input  logic             exit_done,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);

    // The shared timer must hold the larger of the two terminal values
    localparam int C_TMR_MAX = (TIMEOUT_TICKS > CLOSE_TICKS) ? TIMEOUT_TICKS : CLOSE_TICKS;
    localparam int C_TMR_W   = $clog2(C_TMR_MAX + 1);

    localparam logic [C_TMR_W-1:0] C_OPEN_LIMIT  = C_TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [C_TMR_W-1:0] C_CLOSE_LIMIT = C_TMR_W'(CLOSE_TICKS - 1);
    localparam logic [CNT_W-1:0]   C_CAP         = CNT_W'(CAPACITY);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    gate_state_t      state_q,       state_d;
    lane_t            last_grant_q,  last_grant_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic             entry_grant_q, entry_grant_d;
    logic             exit_grant_q,  exit_grant_d;
    logic             gate_open_q,   gate_open_d;
    logic             full_q,        full_d;
    logic             empty_q,       empty_d;
    logic             timeout_err_q, timeout_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_entry_ok;
    logic               w_exit_ok;
    logic               w_tmr_clear;
    logic               w_tmr_en;
    logic               w_tmr_hit;
    logic [C_TMR_W-1:0] w_tmr_limit;
    lane_t              w_rr_lane;

    // Eligibility uses the registered flags, which track count exactly
    assign w_entry_ok = entry_req & ~full_q;
    assign w_exit_ok  = exit_req  & ~empty_q;
    assign w_rr_lane  = rr_pick(last_grant_q);

    // One timer serves both phases: restart on every state change,
    // run whenever the gate is not idle, and compare against the
    // limit belonging to the current phase.
    assign w_tmr_clear = (state_d != state_q);
    assign w_tmr_en    = (state_q != IDLE);
    assign w_tmr_limit = (state_q == CLOSING) ? C_CLOSE_LIMIT : C_OPEN_LIMIT;

    gate_timer #(
        .WIDTH (C_TMR_W)
    ) u_gate_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_tmr_clear),
        .i_enable   (w_tmr_en),
        .i_limit    (w_tmr_limit),
        .o_at_limit (w_tmr_hit)
    );

    // Next-state, arbitration, occupancy update and timeout detection
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        count_d       = count_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_entry_ok && w_exit_ok) begin
                    last_grant_d = w_rr_lane;
                    state_d      = (w_rr_lane == ENTRY) ? OPEN_ENTRY : OPEN_EXIT;
                end else if (w_entry_ok) begin
                    last_grant_d = ENTRY;
                    state_d      = OPEN_ENTRY;
                end else if (w_exit_ok) begin
                    last_grant_d = EXIT;
                    state_d      = OPEN_EXIT;
                end
            end

            OPEN_ENTRY: begin
                // A completed passage takes priority over an expiring timer
                if (entry_done) begin
                    state_d = CLOSING;
                    count_d = (count_q >= C_CAP) ? C_CAP : (count_q + CNT_W'(1));
                end else if (w_tmr_hit) begin
                    state_d       = CLOSING;
                    timeout_err_d = 1'b1;
                end
            end

            OPEN_EXIT: begin
                if (exit_done) begin
                    state_d = CLOSING;
                    count_d = (count_q == '0) ? '0 : (count_q - CNT_W'(1));
                end else if (w_tmr_hit) begin
                    state_d       = CLOSING;
                    timeout_err_d = 1'b1;
                end
            end

            CLOSING: begin
                if (w_tmr_hit) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state and next count so flags line up with count
    always_comb begin
        entry_grant_d = (state_d == OPEN_ENTRY);
        exit_grant_d  = (state_d == OPEN_EXIT);
        gate_open_d   = (state_d == OPEN_ENTRY) || (state_d == OPEN_EXIT);
        full_d        = (count_d == C_CAP);
        empty_d       = (count_d == '0);
    end

    // State and output registers; reset parks the gate closed with an empty lot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= EXIT;
            count_q       <= '0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            gate_open_q   <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            count_q       <= count_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            gate_open_q   <= gate_open_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign gate_open   = gate_open_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign timeout_err = timeout_err_q;

endmodule : parking_gate_arbiter
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_arbiter
// Description : Self-checking bench for parking_gate_arbiter: directed vector
//               table, hand-written corner sequences and randomized traffic
//               against a lane-ownership reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_parking_gate_arbiter;

    localparam int CAP   = 3;
    localparam int CNT_W = 4;
    localparam int TO    = 40;
    localparam int CL    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             entry_req, exit_req, entry_done, exit_done;
    logic             entry_grant, exit_grant, gate_open, full, empty, timeout_err;
    logic [CNT_W-1:0] count;

    parking_gate_arbiter #(
        .CAPACITY      (CAP),
        .CNT_W         (CNT_W),
        .TIMEOUT_TICKS (TO),
        .CLOSE_TICKS   (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .entry_done  (entry_done),
        .exit_done   (exit_done),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .gate_open   (gate_open),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the gate, how long it has been held,
    // how many closing cycles remain, occupancy, and who was served last.
    int m_owner;       // 0 none, 1 entry, 2 exit
    int m_held;
    int m_close_left;
    int m_cnt;
    int m_last;        // 1 entry, 2 exit
    int m_to;

    typedef struct packed {
        logic       er;
        logic       xr;
        logic       ed;
        logic       xd;
        logic       eg;
        logic       xg;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    task automatic add(input logic er, input logic xr, input logic ed, input logic xd,
                       input logic eg, input logic xg, input int cnt, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.er = er; v.xr = xr; v.ed = ed; v.xd = xd;
            v.eg = eg; v.xg = xg; v.cnt = 4'(cnt);
            vecs.push_back(v);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_held = 0; m_close_left = 0; m_cnt = 0; m_last = 2; m_to = 0;
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_step(input logic er, input logic xr, input logic ed, input logic xd);
        bit done_now;
        bit e_ok;
        bit x_ok;
        m_to = 0;
        if (m_owner != 0) begin
            done_now = (m_owner == 1) ? ed : xd;
            if (done_now) begin
                if (m_owner == 1) m_cnt = (m_cnt < CAP) ? m_cnt + 1 : CAP;
                else              m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
                m_owner = 0;
                m_close_left = CL;
            end else if (m_held == TO - 1) begin
                m_to = 1;
                m_owner = 0;
                m_close_left = CL;
            end else begin
                m_held++;
            end
        end else if (m_close_left > 0) begin
            m_close_left--;
        end else begin
            e_ok = er && (m_cnt < CAP);
            x_ok = xr && (m_cnt > 0);
            if (e_ok && x_ok) m_owner = (m_last == 2) ? 1 : 2;
            else if (e_ok)    m_owner = 1;
            else if (x_ok)    m_owner = 2;
            if (m_owner != 0) begin
                m_last = m_owner;
                m_held = 0;
            end
        end
    endtask

    task automatic model_check();
        chk("model_entry_grant", int'(entry_grant), int'(m_owner == 1));
        chk("model_exit_grant",  int'(exit_grant),  int'(m_owner == 2));
        chk("model_gate_open",   int'(gate_open),   int'(m_owner != 0));
        chk("model_count",       int'(count),       m_cnt);
        chk("model_full",        int'(full),        int'(m_cnt == CAP));
        chk("model_empty",       int'(empty),       int'(m_cnt == 0));
        chk("model_timeout_err", int'(timeout_err), m_to);
    endtask

    // Drive inputs, take one edge, then compare against the model
    task automatic cycle(input logic er, input logic xr, input logic ed, input logic xd);
        entry_req = er; exit_req = xr; entry_done = ed; exit_done = xd;
        @(posedge clk);
        model_step(er, xr, ed, xd);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        entry_req = 1'b0; exit_req = 1'b0; entry_done = 1'b0; exit_done = 1'b0;
        #1;
        model_reset();
        chk("rst_count",       int'(count),       0);
        chk("rst_empty",       int'(empty),       1);
        chk("rst_full",        int'(full),        0);
        chk("rst_gate_open",   int'(gate_open),   0);
        chk("rst_entry_grant", int'(entry_grant), 0);
        chk("rst_exit_grant",  int'(exit_grant),  0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        model_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        vec_t v;

        reset = 1'b1;
        entry_req = 1'b0; exit_req = 1'b0; entry_done = 1'b0; exit_done = 1'b0;
        model_reset();

        // Directed table: inputs at an edge, expected grants and count after it
        // empty lot: exit request refused
        add(0,1,0,0, 0,0,0, 10);
        // single entry, done 5 cycles after grant, stray exit_done ignored
        add(1,0,0,0, 1,0,0, 1);
        add(0,0,0,0, 1,0,0, 2);
        add(0,0,0,1, 1,0,0, 1);
        add(0,0,0,0, 1,0,0, 1);
        add(0,0,1,0, 0,0,1, 1);
        add(0,0,1,0, 0,0,1, 1);
        add(0,0,0,0, 0,0,1, 3);
        // second entry granted right after closing
        add(1,0,0,0, 1,0,1, 1);
        add(0,0,0,0, 1,0,1, 2);
        add(0,0,1,0, 0,0,2, 1);
        add(0,0,0,0, 0,0,2, 4);
        // one exit so the last lane served is EXIT
        add(0,1,0,0, 0,1,2, 1);
        add(0,0,0,0, 0,1,2, 2);
        add(0,0,0,1, 0,0,1, 1);
        add(0,0,0,0, 0,0,1, 4);
        add(0,0,1,0, 0,0,1, 1);
        // contention: ENTRY first, then EXIT after closing
        add(1,1,0,0, 1,0,1, 1);
        add(1,1,0,0, 1,0,1, 2);
        add(1,1,1,0, 0,0,2, 1);
        add(1,1,0,0, 0,0,2, 4);
        add(1,1,0,0, 0,1,2, 1);
        add(0,0,0,0, 0,1,2, 1);
        add(0,0,0,1, 0,0,1, 1);
        add(0,0,0,0, 0,0,1, 4);
        // fill the lot
        add(1,0,0,0, 1,0,1, 1);
        add(0,0,1,0, 0,0,2, 1);
        add(0,0,0,0, 0,0,2, 4);
        add(1,0,0,0, 1,0,2, 1);
        add(0,0,1,0, 0,0,3, 1);
        add(0,0,0,0, 0,0,3, 4);
        // full: entry refused, exit proceeds, pending entry then granted
        add(1,0,0,0, 0,0,3, 5);
        add(1,1,0,0, 0,1,3, 1);
        add(1,0,0,1, 0,0,2, 1);
        add(1,0,0,0, 0,0,2, 4);
        add(1,0,0,0, 1,0,2, 1);
        add(0,0,1,0, 0,0,3, 1);
        add(0,0,0,0, 0,0,3, 4);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.er, v.xr, v.ed, v.xd);
            chk($sformatf("vec%0d_entry_grant", i), int'(entry_grant), int'(v.eg));
            chk($sformatf("vec%0d_exit_grant", i),  int'(exit_grant),  int'(v.xg));
            chk($sformatf("vec%0d_count", i),       int'(count),       int'(v.cnt));
            chk($sformatf("vec%0d_full", i),        int'(full),        int'(v.cnt == 4'(CAP)));
            chk($sformatf("vec%0d_empty", i),       int'(empty),       int'(v.cnt == 4'd0));
        end

        // Timeout: grant held with no done pulse
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("to_grant", int'(entry_grant), 1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 60) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("to_latency", k, TO);
        chk("to_count_unchanged", int'(count), 0);
        chk("to_gate_closed", int'(gate_open), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_pulse_width", int'(timeout_err), 0);
        for (int i = 0; i < CL; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Done arriving on the same edge as the timeout wins
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("race_no_timeout", int'(timeout_err), 0);
        chk("race_count", int'(count), 1);
        for (int i = 0; i < CL; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-grant in OPEN_EXIT
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_exit_grant", int'(exit_grant), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_gate_open", int'(gate_open), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_exit_grant", int'(exit_grant), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stray_exit_done_count", int'(count), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 99) < 60),
                  logic'($urandom_range(0, 99) < 50),
                  logic'($urandom_range(0, 11) == 0),
                  logic'($urandom_range(0, 11) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_parking_gate_arbiter
`default_nettype wire
